exe_seq: RTL and testbench

EXE_SEQ -- requirements
Module: exe_seq

---
 rtl/exe_seq.sv | 86 ++++++++
 tb/tb_exe_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/exe_seq.sv
// Block/element execution sequencer: walks blocks 0..i_last, and per block
// elements 0..j_last, emitting compute cycles and source/matrix read addresses.
module exe_seq #(
  parameter int I_W = 2,
  parameter int J_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_init,
  input  logic [I_W-1:0]   i_last_cfg,
  input  logic [J_W-1:0]   j_last_cfg,
  input  logic             stall,
  input  logic             abort,
  input  logic             out_busy,
  input  logic             out_fin,
  output logic             k_init,
  output logic             exec,
  output logic [I_W+J_W-1:0] exec_src_addr,
  output logic [J_W-1:0]   exec_mat_addr,
  output logic             k_fin,
  output logic             s_fin,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_RUN, S_KFIN, S_WAIT_OUT, S_DONE
  } state_t;

  state_t         r_state, w_nxt;
  logic [I_W-1:0] r_i, r_i_last;
  logic [J_W-1:0] r_j, r_j_last;
  logic           w_run;

  assign w_run = (r_state == S_RUN);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:     if (s_init) w_nxt = S_ARM;
      S_ARM:      if (!out_busy) w_nxt = S_RUN;
      S_RUN:      if (!stall && (r_j == r_j_last)) w_nxt = S_KFIN;
      S_KFIN:     w_nxt = (r_i == r_i_last) ? S_WAIT_OUT : S_ARM;
      S_WAIT_OUT: if (out_fin) w_nxt = S_DONE;
      S_DONE:     w_nxt = S_IDLE;
      default:    w_nxt = S_IDLE;
    endcase
    if (abort) w_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_i      <= '0;
      r_j      <= '0;
      r_i_last <= '0;
      r_j_last <= '0;
    end else begin
      r_state <= w_nxt;
      // Counters only advance on non-aborted cycles; an abort leaves them for the next s_init to clear.
      if (!abort) begin
        case (r_state)
          S_IDLE: if (s_init) begin
            r_i_last <= i_last_cfg;
            r_j_last <= j_last_cfg;
            r_i      <= '0;
            r_j      <= '0;
          end
          S_ARM:  if (!out_busy) r_j <= '0;
          S_RUN:  if (!stall && (r_j != r_j_last)) r_j <= r_j + 1'b1;
          S_KFIN: if (r_i != r_i_last) r_i <= r_i + 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Done pulses are suppressed in an aborted cycle so a cancelled job never reports completion.
  assign k_init        = (r_state == S_ARM) && !out_busy;
  assign exec          = w_run && !stall;
  assign exec_src_addr = w_run ? {r_i, r_j} : '0;
  assign exec_mat_addr = w_run ? r_j : '0;
  assign k_fin         = (r_state == S_KFIN) && !abort;
  assign s_fin         = (r_state == S_DONE) && !abort;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_exe_seq.sv
// Self-checking bench for exe_seq: directed scenarios plus randomized jobs
// scored against an expected address stream built from the job configuration.
module tb_exe_seq;
  localparam int I_W = 2;
  localparam int J_W = 6;
  localparam int BLK = 1 << J_W;

  logic clk = 1'b0;
  logic rst, s_init, stall, abort, out_busy, out_fin;
  logic [I_W-1:0] i_last_cfg;
  logic [J_W-1:0] j_last_cfg;
  logic k_init, exec, k_fin, s_fin, busy;
  logic [I_W+J_W-1:0] exec_src_addr;
  logic [J_W-1:0] exec_mat_addr;

  exe_seq #(.I_W(I_W), .J_W(J_W)) dut (
    .clk(clk), .rst(rst), .s_init(s_init), .i_last_cfg(i_last_cfg),
    .j_last_cfg(j_last_cfg), .stall(stall), .abort(abort), .out_busy(out_busy),
    .out_fin(out_fin), .k_init(k_init), .exec(exec), .exec_src_addr(exec_src_addr),
    .exec_mat_addr(exec_mat_addr), .k_fin(k_fin), .s_fin(s_fin), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;
  int cyc = 0;
  int exp_q[$];
  int mode, cur_jl, exec_cnt, kinit_cnt, kfin_cnt, exec_in_blk;
  int last_exec, last_kinit, last_kfin, busy_left, stall_left;
  bit lat_on;
  int s_src, s_mat, s_exec, s_kinit, s_kfin, s_sfin, s_busy;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs at negedge, score them, then advance past posedge.
  task automatic tick();
    int e;
    @(negedge clk);
    cyc++;
    s_src = int'(exec_src_addr); s_mat = int'(exec_mat_addr); s_exec = int'(exec);
    s_kinit = int'(k_init); s_kfin = int'(k_fin); s_sfin = int'(s_fin); s_busy = int'(busy);
    if (exec) begin
      if (exp_q.size() == 0) chk("exec_extra", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("src_addr", s_src, e);
        chk("mat_addr", s_mat, e % BLK);
      end
      chk("exec_while_stall", int'(stall), 0);
      if (lat_on && exec_in_blk == 0) chk("kinit_to_exec", cyc - last_kinit, 1);
      exec_cnt++; exec_in_blk++; last_exec = cyc;
    end
    if (k_init) begin
      chk("kinit_while_busy", int'(out_busy), 0);
      kinit_cnt++;
      if (lat_on) chk("kinit_lat", cyc - last_kfin, 1);
      if (mode == 2 && kinit_cnt == 2) chk("arm_hold", cyc - last_kfin, 6);
      last_kinit = cyc; exec_in_blk = 0;
    end
    if (k_fin) begin
      chk("exec_to_kfin", cyc - last_exec, 1);
      chk("blk_len", exec_in_blk, cur_jl + 1);
      kfin_cnt++; last_kfin = cyc;
      if (mode == 2 && kfin_cnt == 1) busy_left = 5;
    end
    @(posedge clk); #1;
  endtask

  task automatic run_job(input int il, input int jl, input int md);
    int guard, tmp;
    bit stall_app, busy_app, kill;
    logic [31:0] c_il, c_jl;
    mode = md; cur_jl = jl; exec_cnt = 0; kinit_cnt = 0; kfin_cnt = 0; exec_in_blk = 0;
    busy_left = 0; stall_left = (md == 3) ? 3 : 0;
    lat_on = (md != 1 && md != 2);
    exp_q.delete();
    for (int b = 0; b <= il; b++)
      for (int e = 0; e <= jl; e++) exp_q.push_back(b * BLK + e);
    c_il = il; c_jl = jl;
    i_last_cfg = c_il[I_W-1:0]; j_last_cfg = c_jl[J_W-1:0];
    s_init = 1'b1; stall = 1'b0; out_busy = 1'b0; out_fin = 1'b0; abort = 1'b0;
    tick();
    last_kfin = cyc;
    s_init = 1'b0;
    // Scramble cfg inputs: the job must keep using the values latched at s_init.
    tmp = $urandom; c_il = tmp; i_last_cfg = c_il[I_W-1:0];
    tmp = $urandom; c_jl = tmp; j_last_cfg = c_jl[J_W-1:0];
    guard = 0;
    while (kfin_cnt < il + 1) begin
      guard++;
      if (guard > 3000) begin
        chk("job_timeout", 0, 1);
        exp_q.delete(); rst = 1'b1; tick(); rst = 1'b0;
        return;
      end
      stall    = (md == 1) ? ($urandom_range(3, 0) == 0) : 1'b0;
      out_busy = (md == 1) ? ($urandom_range(2, 0) == 0) : 1'b0;
      s_init   = (md == 1) ? ($urandom_range(7, 0) == 0) : 1'b0;
      out_fin  = (md == 1) ? ($urandom_range(5, 0) == 0) :
                 (md == 4 && kinit_cnt == 1 && exec_cnt == 0);
      busy_app = (busy_left > 0);
      if (busy_app) begin out_busy = 1'b1; busy_left--; end
      stall_app = (md == 3 && stall_left > 0 && kinit_cnt == 1 && exec_in_blk == 2);
      if (stall_app) begin stall = 1'b1; stall_left--; end
      kill = (md == 5 && kinit_cnt == 2 && exec_in_blk == 10) || (md == 6 && exec_cnt == 20);
      if (kill) begin
        if (md == 5) abort = 1'b1; else rst = 1'b1;
        tick();
        chk("kill_kfin", s_kfin, 0); chk("kill_sfin", s_sfin, 0);
        abort = 1'b0; rst = 1'b0;
        tick();
        chk("kill_busy", s_busy, 0); chk("kill_exec", s_exec, 0);
        chk("kill_kinit", s_kinit, 0); chk("kill_src", s_src, 0);
        tick();
        chk("kill_idle_busy", s_busy, 0); chk("kill_idle_kfin", s_kfin, 0);
        exp_q.delete();
        return;
      end
      tick();
      if (busy_app) begin chk("arm_kinit_busy", s_kinit, 0); chk("arm_busy", s_busy, 1); end
      if (stall_app) begin
        chk("stall_exec", s_exec, 0); chk("stall_src", s_src, 2); chk("stall_mat", s_mat, 2);
      end
    end
    stall = 1'b0; out_busy = 1'b0; s_init = 1'b0; out_fin = 1'b0;
    chk("exec_total", exec_cnt, (il + 1) * (jl + 1));
    chk("kinit_total", kinit_cnt, il + 1);
    chk("stream_left", exp_q.size(), 0);
    repeat (2) begin
      tick(); chk("wait_sfin", s_sfin, 0); chk("wait_busy", s_busy, 1); chk("wait_exec", s_exec, 0);
    end
    out_fin = 1'b1; tick(); out_fin = 1'b0;
    chk("sfin_early", s_sfin, 0);
    tick(); chk("sfin", s_sfin, 1); chk("done_busy", s_busy, 1);
    tick(); chk("sfin_width", s_sfin, 0); chk("idle_busy", s_busy, 0);
  endtask

  initial begin
    rst = 1'b1; s_init = 1'b1; abort = 1'b1; stall = 1'b0; out_busy = 1'b0; out_fin = 1'b0;
    i_last_cfg = '0; j_last_cfg = '0;
    mode = 0; cur_jl = 0; lat_on = 1'b0; exec_in_blk = 0;
    last_exec = 0; last_kinit = 0; last_kfin = 0; busy_left = 0; stall_left = 0;
    exec_cnt = 0; kinit_cnt = 0; kfin_cnt = 0;
    tick(); tick();
    chk("rst_kinit", s_kinit, 0); chk("rst_exec", s_exec, 0); chk("rst_src", s_src, 0);
    chk("rst_mat", s_mat, 0); chk("rst_kfin", s_kfin, 0); chk("rst_sfin", s_sfin, 0);
    chk("rst_busy", s_busy, 0);
    rst = 1'b0; s_init = 1'b0; abort = 1'b0;
    tick(); chk("idle_busy0", s_busy, 0);

    run_job(3, 63, 0);   // full default job
    run_job(1, 3, 2);    // output stage busy after first block
    run_job(0, 7, 3);    // stall burst at j=2
    run_job(0, 0, 4);    // early out_fin ignored
    run_job(2, 15, 5);   // abort mid block 1
    run_job(1, 5, 0);    // restart from address 0
    run_job(3, 10, 6);   // reset mid job
    run_job(2, 4, 0);
    repeat (6) run_job($urandom_range(3, 0), $urandom_range(15, 0), 1);
    run_job(0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
